// File: rtl/alu_arbiter_if.sv
// Bundle of the RS, LSB, shared-ALU and CDB signals around the ALU arbiter.
// slave = arbiter view, master = surrounding core (or bench) view.
interface alu_arbiter_if #(
  parameter int ROB_W = 4
);
  logic             rdy;
  logic             clear;

  logic             rs_valid;
  logic             rs_ready;
  logic [5:0]       rs_opcode;
  logic [31:0]      rs_lhs;
  logic [31:0]      rs_rhs;
  logic [31:0]      rs_imm;
  logic [31:0]      rs_pc;
  logic [ROB_W-1:0] rs_rob;

  logic             lsb_valid;
  logic             lsb_ready;
  logic [5:0]       lsb_opcode;
  logic [31:0]      lsb_lhs;
  logic [31:0]      lsb_rhs;
  logic [31:0]      lsb_imm;
  logic [31:0]      lsb_pc;
  logic [ROB_W-1:0] lsb_rob;

  logic             alu_valid;
  logic [5:0]       alu_opcode;
  logic [31:0]      alu_lhs;
  logic [31:0]      alu_rhs;
  logic [31:0]      alu_imm;
  logic [31:0]      alu_pc;
  logic [31:0]      alu_result;

  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob;
  logic [31:0]      cdb_result;
  logic             cdb_ready;

  logic             lsb_addr_valid;
  logic [ROB_W-1:0] lsb_addr_rob;
  logic [31:0]      lsb_addr;

  modport slave (
    input  rdy, clear,
    input  rs_valid, rs_opcode, rs_lhs, rs_rhs, rs_imm, rs_pc, rs_rob,
    output rs_ready,
    input  lsb_valid, lsb_opcode, lsb_lhs, lsb_rhs, lsb_imm, lsb_pc, lsb_rob,
    output lsb_ready,
    output alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc,
    input  alu_result,
    output cdb_valid, cdb_rob, cdb_result,
    input  cdb_ready,
    output lsb_addr_valid, lsb_addr_rob, lsb_addr
  );

  modport master (
    output rdy, clear,
    output rs_valid, rs_opcode, rs_lhs, rs_rhs, rs_imm, rs_pc, rs_rob,
    input  rs_ready,
    output lsb_valid, lsb_opcode, lsb_lhs, lsb_rhs, lsb_imm, lsb_pc, lsb_rob,
    input  lsb_ready,
    input  alu_valid, alu_opcode, alu_lhs, alu_rhs, alu_imm, alu_pc,
    output alu_result,
    input  cdb_valid, cdb_rob, cdb_result,
    output cdb_ready,
    input  lsb_addr_valid, lsb_addr_rob, lsb_addr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the RS and the LSB.
// A single output slot holds the result: RS results wait for a CDB slot, LSB addresses pulse once.
module alu_arbiter #(
  parameter int ROB_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_RS  = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] imm;
    logic [31:0] pc;
  } alu_op_t;

  typedef struct packed {
    logic             valid;
    src_e             src;
    logic [ROB_W-1:0] rob;
    logic [31:0]      result;
  } slot_t;

  slot_t            slot_q, slot_d;
  src_e             last_q, last_d;
  logic             slot_free;
  logic             can_grant;
  logic             gnt_rs, gnt_lsb, gnt_any;
  logic [ROB_W-1:0] gnt_rob;
  alu_op_t          rs_op, lsb_op, issue_op;

  assign rs_op  = '{opcode: bus.rs_opcode,  lhs: bus.rs_lhs,  rhs: bus.rs_rhs,
                    imm: bus.rs_imm,  pc: bus.rs_pc};
  assign lsb_op = '{opcode: bus.lsb_opcode, lhs: bus.lsb_lhs, rhs: bus.lsb_rhs,
                    imm: bus.lsb_imm, pc: bus.lsb_pc};

  // LSB results never wait, so only a held RS result without a CDB slot blocks issue.
  assign slot_free = !slot_q.valid || (slot_q.src == SRC_LSB) || bus.cdb_ready;
  assign can_grant = bus.rdy && !bus.clear && !rst && slot_free;

  // last_q names the previous winner; a tie goes to the other source.
  assign gnt_rs  = can_grant && bus.rs_valid  && (!bus.lsb_valid || last_q == SRC_LSB);
  assign gnt_lsb = can_grant && bus.lsb_valid && (!bus.rs_valid  || last_q == SRC_RS);
  assign gnt_any = gnt_rs || gnt_lsb;

  always_comb begin
    issue_op = '0;
    gnt_rob  = '0;
    if (gnt_rs) begin
      issue_op = rs_op;
      gnt_rob  = bus.rs_rob;
    end else if (gnt_lsb) begin
      issue_op = lsb_op;
      gnt_rob  = bus.lsb_rob;
    end
  end

  always_comb begin
    slot_d = slot_q;
    last_d = last_q;
    if (bus.clear) begin
      slot_d.valid = 1'b0;
    end else if (bus.rdy) begin
      if (gnt_any) begin
        slot_d.valid  = 1'b1;
        slot_d.src    = gnt_lsb ? SRC_LSB : SRC_RS;
        slot_d.rob    = gnt_rob;
        slot_d.result = bus.alu_result;
        last_d        = gnt_lsb ? SRC_LSB : SRC_RS;
      end else if (slot_q.valid && slot_free) begin
        slot_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      last_q <= SRC_LSB;
    end else begin
      slot_q <= slot_d;
      last_q <= last_d;
    end
  end

  assign bus.rs_ready   = gnt_rs;
  assign bus.lsb_ready  = gnt_lsb;
  assign bus.alu_valid  = gnt_any;
  assign bus.alu_opcode = issue_op.opcode;
  assign bus.alu_lhs    = issue_op.lhs;
  assign bus.alu_rhs    = issue_op.rhs;
  assign bus.alu_imm    = issue_op.imm;
  assign bus.alu_pc     = issue_op.pc;

  // Slot outputs are forced low while rst is high so a pending result is never broadcast.
  assign bus.cdb_valid      = !rst && slot_q.valid && (slot_q.src == SRC_RS);
  assign bus.cdb_rob        = bus.cdb_valid ? slot_q.rob : '0;
  assign bus.cdb_result     = bus.cdb_valid ? slot_q.result : '0;
  assign bus.lsb_addr_valid = !rst && slot_q.valid && (slot_q.src == SRC_LSB);
  assign bus.lsb_addr_rob   = bus.lsb_addr_valid ? slot_q.rob : '0;
  assign bus.lsb_addr       = bus.lsb_addr_valid ? slot_q.result : '0;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: ROB_W, 4, ROB entry tag width.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low = freeze.
- clear  in  1  ROB flush on misprediction.
- rs_valid  in  1  RS request present.
- rs_ready  out  1  RS request accepted this cycle.
- rs_opcode/rs_lhs/rs_rhs/rs_imm/rs_pc  in  6/32/32/32/32  RS operands.
- rs_rob  in  ROB_W  RS destination tag.
- lsb_valid  in  1  LSB address-calc request present.
- lsb_ready  out  1  LSB request accepted this cycle.
- lsb_opcode/lsb_lhs/lsb_rhs/lsb_imm/lsb_pc  in  6/32/32/32/32  LSB operands.
- lsb_rob  in  ROB_W  LSB entry tag.
- alu_valid  out  1  ALU issue strobe.
- alu_opcode/alu_lhs/alu_rhs/alu_imm/alu_pc  out  6/32/32/32/32  operands to shared ALU.
- alu_result  in  32  combinational ALU result, same cycle as issue.
- cdb_valid  out  1  RS result broadcast pending.
- cdb_rob  out  ROB_W  broadcast tag.
- cdb_result  out  32  broadcast value.
- cdb_ready  in  1  CDB slot granted this cycle.
- lsb_addr_valid  out  1  LSB address result, one-cycle pulse.
- lsb_addr_rob  out  ROB_W  tag of returned address.
- lsb_addr  out  32  computed address.

Function
REQ-003 SHALL hold one output slot register: {valid, src (RS/LSB), rob, result}.
REQ-004 Slot SHALL be free when: !slot_valid, or src=LSB, or (src=RS and cdb_ready).
REQ-005 Grant SHALL occur only when rdy=1, clear=0, rst=0, slot free, at least one request valid.
REQ-006 Arbitration SHALL be round-robin: both valid -> grant the source not granted last; one valid -> grant it.
REQ-007 Last-grant pointer SHALL update only on a grant; after reset, RS wins the first tie.
REQ-008 rs_ready/lsb_ready SHALL be combinational, one-hot or zero, equal to the grant.
REQ-009 On grant, alu_valid=1 and alu_* SHALL carry the granted source's fields; with no grant, alu_valid=0 and alu_* = 0.
REQ-010 Latency SHALL be 1 cycle: grant at cycle N -> slot loaded at edge ending N with {1, src, rob, alu_result}; visible from cycle N+1.
REQ-011 cdb_valid=slot_valid & src=RS; cdb_rob/cdb_result SHALL come from the slot and stay stable until cdb_ready=1 at an edge.
REQ-012 lsb_addr_valid=slot_valid & src=LSB for exactly one cycle, with no backpressure; lsb_addr_rob/lsb_addr SHALL come from the slot.
REQ-013 Slot SHALL clear at an edge when drained (LSB, or RS with cdb_ready) and there is no new grant.
REQ-014 Drain and new grant in the same cycle SHALL reload the slot back-to-back with no bubble.
REQ-015 clear=1 SHALL invalidate the slot at that edge and suppress grants that cycle; pointer unchanged.
REQ-016 clear SHALL act regardless of rdy.
REQ-017 rdy=0 (clear=0) SHALL hold all registers; ready outputs and alu_valid SHALL be 0; slot outputs hold.
REQ-018 Opcode SHALL pass through unchecked; the block SHALL not decode opcodes.

Reset
REQ-019 rst=1 at an edge SHALL clear slot valid, src, rob and result to 0 and set the pointer so RS wins the next tie.
REQ-020 rst SHALL have priority over clear and rdy.
REQ-021 During the rst=1 cycle, all outputs SHALL be 0.
REQ-022 rst asserted with cdb_valid pending SHALL drop the pending result with no broadcast.

Verification
REQ-023 RS only: ADD lhs=5, rhs=7, rob=3, cdb_ready=1 -> next cycle cdb_valid=1, cdb_rob=3, cdb_result=12; cleared the following cycle.
REQ-024 Both valid for 4 cycles, cdb_ready=1 -> grant order RS, LSB, RS, LSB; lsb_addr_valid pulses at cycles 3 and 5.
REQ-025 RS result, cdb_ready=0 for 3 cycles with RS and LSB valid -> no grants, cdb outputs stable; cdb_ready=1 -> drain plus same-cycle new grant.
REQ-026 clear asserted while cdb_valid=1 and both requests valid -> next cycle cdb_valid=0, no ready asserted that cycle.
REQ-027 rdy=0 for 2 cycles with a pending slot -> slot and pointer unchanged; resumes identically when rdy=1.
REQ-028 rst mid-stream with slot valid -> all outputs 0; first tie after reset grants RS.
